cbus_rr_arbiter: RTL

- Parametrised N-port CBus arbiter. Successor to the fixed two-port instruction/data arbiter.
- Merges NUM_PORTS cached/uncached requesters (I-cache, D-cache, uncached D-port, future DMA/TLB walker) onto one CBus master feeding the address translator.
- Adds a selectable fixed-priority or round-robin policy, plus grant hold across multi-beat bursts.
- Adds optional early release when a requester withdraws its request.

---
 rtl/cbus_rr_arbiter_pkg.sv | 32 +++
 rtl/cbus_rr_arbiter_rr_picker.sv | 42 ++++
 rtl/cbus_rr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared definitions for the N-port CBus arbiter: bus request/response layouts,
// arbiter FSM state and the grant-index width helper.
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 8;

    function automatic int idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// Combinational winner selection: fixed priority (lowest index) or a rotating
// search that starts at ptr_i and wraps modulo NUM_PORTS.
module cbus_rr_arbiter_rr_picker
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    localparam int IDX_W     = idx_width(NUM_PORTS),
    localparam int SUM_W     = IDX_W + 1
) (
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [IDX_W-1:0]     ptr_i,
    input  logic                 rr_en_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic                 any_valid_o
);

    logic [IDX_W-1:0]     cand_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand_hit;

    // Candidate gi is the port searched at position gi of the scan order.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;

        assign sum = {1'b0, ptr_i} + SUM_W'(gi);
        assign cand_idx[gi] = !rr_en_i                        ? IDX_W'(gi) :
                              (sum >= SUM_W'(NUM_PORTS))      ? IDX_W'(sum - SUM_W'(NUM_PORTS)) :
                                                                IDX_W'(sum);
        assign cand_hit[gi] = valid_i[cand_idx[gi]];
    end

    always_comb begin
        winner_o = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner_o = cand_idx[k];
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-port CBus arbiter: registers a winner in IDLE, then forwards that port's
// request and the downstream response until ready&&last (or an early drop).
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int  NUM_PORTS     = 2,
    parameter int  ROUND_ROBIN   = 1,
    parameter int  ABORT_ON_DROP = 1,
    localparam int IDX_W         = idx_width(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  cbus_req_t  [NUM_PORTS-1:0] ireqs,
    output cbus_resp_t [NUM_PORTS-1:0] iresps,
    output cbus_req_t                  oreq,
    input  cbus_resp_t                 oresp,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_idx
);

    if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
        $error("cbus_rr_arbiter: NUM_PORTS=%0d outside %0d..%0d", NUM_PORTS, MIN_PORTS, MAX_PORTS);
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W-1:0]     winner;
    logic                 any_valid;
    logic                 done;
    logic                 dropped;
    logic [NUM_PORTS-1:0] req_valid;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
        assign req_valid[gi] = ireqs[gi].valid;
    end

    cbus_rr_arbiter_rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .valid_i     (req_valid),
        .ptr_i       (rr_ptr_q),
        .rr_en_i     (ROUND_ROBIN != 0),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    // Completion wins over a simultaneous drop; both release the same way.
    assign done     = oresp.ready && oresp.last;
    assign dropped  = (ABORT_ON_DROP != 0) && !ireqs[sel_q].valid;
    assign next_ptr = (sel_q == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    sel_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done || dropped) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Only the registered grantee is steered; everyone else sees an all-zero response.
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (state_q == GRANT) begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
        end
    end

    assign busy      = (state_q == GRANT);
    assign grant_idx = sel_q;

endmodule
